// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash responder (READ 0x03, JEDEC ID 0x9F) sampled in an oversampling clk domain.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to add FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID       = 24'hEF4016,
  parameter int unsigned MIN_OVERSAMPLE = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flash_clk,
  input  logic        flash_csn,
  input  logic        flash_io0_in,
  output logic        flash_io1_out,
  output logic        flash_io1_en,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    DUMMY,
`endif
    DATA,
    ID,
    IGNORE
  } state_t;

  // Two sync stages plus the edge detector leave too little margin below this ratio.
  if (MIN_OVERSAMPLE < 4) begin : g_ratio_check
    $error("spi_flash_responder: MIN_OVERSAMPLE must be at least 4");
  end

  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       csn_meta, csn_sync;
  logic       io0_meta, io0_sync;
  logic [1:0] sync_settle;
  logic       sclk_rise, sclk_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_meta   <= 1'b0;
      sclk_sync   <= 1'b0;
      sclk_prev   <= 1'b0;
      csn_meta    <= 1'b1;
      csn_sync    <= 1'b1;
      io0_meta    <= 1'b0;
      io0_sync    <= 1'b0;
      sync_settle <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value,
      // which is what builds a real flop chain instead of collapsing it into one wire.
      sclk_meta   <= flash_clk;
      sclk_sync   <= sclk_meta;
      sclk_prev   <= sclk_sync;
      csn_meta    <= flash_csn;
      csn_sync    <= csn_meta;
      io0_meta    <= flash_io0_in;
      io0_sync    <= io0_meta;
      sync_settle <= {sync_settle[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_in;
  logic [7:0]  data_byte;
  logic [2:0]  bit_idx;
  logic [1:0]  id_idx;
  logic        rd_pending;
  logic        armed;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_word;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic        fast_rd;
`endif

  assign cmd_byte  = {shift_in[6:0], io0_sync};
  assign addr_word = {shift_in[22:0], io0_sync};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= 5'd0;
      shift_in      <= 23'd0;
      data_byte     <= 8'd0;
      bit_idx       <= 3'd7;
      id_idx        <= 2'd0;
      rd_pending    <= 1'b0;
      armed         <= 1'b0;
      flash_io1_out <= 1'b0;
      flash_io1_en  <= 1'b0;
      mem_rd        <= 1'b0;
      mem_addr      <= 24'd0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast_rd       <= 1'b0;
`endif
    end else begin
      mem_rd     <= 1'b0;
      rd_pending <= mem_rd;
      if (rd_pending) data_byte <= mem_rdata;
      // Only a high csn seen after the synchronizers settle arms the next transfer,
      // so a csn already low when reset releases never looks like a fresh fall.
      if (sync_settle[1] && csn_sync) armed <= 1'b1;

      if (csn_sync) begin
        state         <= IDLE;
        bit_cnt       <= 5'd0;
        flash_io1_en  <= 1'b0;
        flash_io1_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state   <= CMD;
              bit_cnt <= 5'd0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[21:0], io0_sync};
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                bit_idx <= 3'd7;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                fast_rd <= (cmd_byte == 8'h0B);
`endif
                case (cmd_byte)
                  8'h03: state <= ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                  8'h0B: state <= ADDR;
`endif
                  8'h9F: begin
                    state     <= ID;
                    data_byte <= JEDEC_ID[23:16];
                    id_idx    <= 2'd1;
                  end
                  default: state <= IGNORE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[21:0], io0_sync};
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= 5'd0;
                mem_rd   <= 1'b1;
                mem_addr <= addr_word;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                state    <= fast_rd ? DUMMY : DATA;
`else
                state    <= DATA;
`endif
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          DUMMY: begin
            if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= 5'd0;
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`endif
          DATA: begin
            if (sclk_fall) begin
              flash_io1_en  <= 1'b1;
              flash_io1_out <= data_byte[bit_idx];
              // Prefetch as the last bit goes out; the byte lands two clk later, well before the next fall.
              if (bit_idx == 3'd0) begin
                bit_idx  <= 3'd7;
                mem_rd   <= 1'b1;
                mem_addr <= mem_addr + 24'd1;
              end else begin
                bit_idx <= bit_idx - 3'd1;
              end
            end
          end
          ID: begin
            if (sclk_fall) begin
              flash_io1_en  <= 1'b1;
              flash_io1_out <= data_byte[bit_idx];
              if (bit_idx == 3'd0) begin
                bit_idx <= 3'd7;
                case (id_idx)
                  2'd1:    data_byte <= JEDEC_ID[15:8];
                  2'd2:    data_byte <= JEDEC_ID[7:0];
                  default: data_byte <= 8'hFF;
                endcase
                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
              end else begin
                bit_idx <= bit_idx - 3'd1;
              end
            end
          end
          IGNORE: begin
            flash_io1_en <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: a mode-0 host model, a memory returning memory[i]=i[7:0],
// and scoreboard queues of expected MISO bytes and mem_rd addresses.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flash_clk = 1'b0;
  logic        flash_csn = 1'b1;
  logic        flash_io0_in = 1'b0;
  logic        flash_io1_out;
  logic        flash_io1_en;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] addr_q[$];
  logic [23:0] mon_addr;

  spi_flash_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flash_clk    (flash_clk),
    .flash_csn    (flash_csn),
    .flash_io0_in (flash_io0_in),
    .flash_io1_out(flash_io1_out),
    .flash_io1_en (flash_io1_en),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  // clk rises at 5, 15, 25 ...; all host stimulus moves on multiples of 10, away from those edges.
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  always @(negedge clk) begin
    if (reset_n && mem_rd) begin
      n_vec++;
      if (addr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_mem_rd: mem_rd seen at addr %h, required no read", mem_addr);
      end else begin
        mon_addr = addr_q.pop_front();
        if (mem_addr !== mon_addr) begin
          n_err++;
          $display("FAIL mem_addr: got %h, required %h", mem_addr, mon_addr);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One mode-0 byte: MOSI set while sclk low, MISO/enable sampled late in the low phase.
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic en_any, output logic en_all);
    rx = 8'h00;
    en_any = 1'b0;
    en_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      flash_io0_in = tx[i];
      #30;
      rx[i]  = flash_io1_out;
      en_any = en_any | (flash_io1_en === 1'b1);
      en_all = en_all & (flash_io1_en === 1'b1);
      #10 flash_clk = 1'b1;
      #40 flash_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    flash_csn = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40 flash_csn = 1'b1;
    #80;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, output logic en_seen);
    logic [7:0] rx;
    logic       ea, el;
    en_seen = 1'b0;
    spi_byte(op, rx, ea, el);          en_seen = en_seen | ea;
    spi_byte(addr[23:16], rx, ea, el); en_seen = en_seen | ea;
    spi_byte(addr[15:8], rx, ea, el);  en_seen = en_seen | ea;
    spi_byte(addr[7:0], rx, ea, el);   en_seen = en_seen | ea;
  endtask

  task automatic read_bytes(input logic [23:0] addr, input int n);
    logic [7:0]  rx, exp_b;
    logic [23:0] a;
    logic        hdr_en, ea, el;
    for (int k = 0; k <= n; k++) begin
      a = addr + 24'(k);
      addr_q.push_back(a);
      if (k < n) exp_q.push_back(a[7:0]);
    end
    send_hdr(8'h03, addr, hdr_en);
    n_vec++;
    if (hdr_en !== 1'b0) begin
      n_err++;
      $display("FAIL read_hdr_en: io1_en seen %b during command/address, required 0", hdr_en);
    end
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, rx, ea, el);
      exp_b = exp_q.pop_front();
      n_vec++;
      if (rx !== exp_b) begin
        n_err++;
        $display("FAIL read_data[%0d]: got %h, required %h", k, rx, exp_b);
      end
      n_vec++;
      if (el !== 1'b1) begin
        n_err++;
        $display("FAIL read_en[%0d]: io1_en all-high %b, required 1", k, el);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #40;
    n_vec += 4;
    if (flash_io1_en !== 1'b0)  begin n_err++; $display("FAIL reset_io1_en: got %b, required 0", flash_io1_en); end
    if (flash_io1_out !== 1'b0) begin n_err++; $display("FAIL reset_io1_out: got %b, required 0", flash_io1_out); end
    if (mem_rd !== 1'b0)        begin n_err++; $display("FAIL reset_mem_rd: got %b, required 0", mem_rd); end
    if (mem_addr !== 24'h0)     begin n_err++; $display("FAIL reset_mem_addr: got %h, required 000000", mem_addr); end
    reset_n = 1'b1;
    #60;
  endtask

  task automatic test_read();
    cs_low();
    read_bytes(24'h000010, 4);
    cs_high();
    n_vec++;
    if (flash_io1_en !== 1'b0) begin
      n_err++;
      $display("FAIL read_en_after_cs: got %b, required 0", flash_io1_en);
    end
  endtask

  task automatic test_jedec_id();
    logic [7:0] rx, exp_b;
    logic       ea, el;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h16);
    exp_q.push_back(8'hFF);
    cs_low();
    spi_byte(8'h9F, rx, ea, el);
    n_vec++;
    if (ea !== 1'b0) begin n_err++; $display("FAIL id_cmd_en: got %b, required 0", ea); end
    for (int k = 0; k < 4; k++) begin
      spi_byte(8'h00, rx, ea, el);
      exp_b = exp_q.pop_front();
      n_vec += 2;
      if (rx !== exp_b) begin n_err++; $display("FAIL id_byte[%0d]: got %h, required %h", k, rx, exp_b); end
      if (el !== 1'b1)  begin n_err++; $display("FAIL id_en[%0d]: got %b, required 1", k, el); end
    end
    cs_high();
  endtask

  task automatic test_wrap();
    cs_low();
    read_bytes(24'hFFFFFE, 3);
    cs_high();
  endtask

  task automatic test_csn_abort();
    logic hdr_en;
    addr_q.push_back(24'h000030);
    cs_low();
    send_hdr(8'h03, 24'h000030, hdr_en);
    flash_io0_in = 1'b0;
    #30;
    n_vec++;
    if (flash_io1_en !== 1'b1) begin n_err++; $display("FAIL abort_en_active: got %b, required 1", flash_io1_en); end
    #10 flash_clk = 1'b1;
    #40 flash_clk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #40 flash_clk = 1'b1;
      #40 flash_clk = 1'b0;
    end
    flash_csn = 1'b1;
    #30;
    n_vec++;
    if (flash_io1_en !== 1'b0) begin n_err++; $display("FAIL abort_en_drop: got %b, required 0 within 3 clk", flash_io1_en); end
    #200;
    cs_low();
    read_bytes(24'h000020, 1);
    cs_high();
  endtask

  task automatic test_ignore_fast();
    logic [7:0] rx, exp_b;
    logic       ea, el, hdr_en;
    cs_low();
    spi_byte(8'hAB, rx, ea, el);
    spi_byte(8'h00, rx, ea, el);
    spi_byte(8'h00, rx, ea, el);
    n_vec++;
    if (ea !== 1'b0) begin n_err++; $display("FAIL ignore_ab_en: got %b, required 0", ea); end
    cs_high();
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    addr_q.push_back(24'h000005);
    addr_q.push_back(24'h000006);
    exp_q.push_back(8'h05);
`endif
    cs_low();
    send_hdr(8'h0B, 24'h000005, hdr_en);
    spi_byte(8'h00, rx, ea, el);
    n_vec += 2;
    if (hdr_en !== 1'b0) begin n_err++; $display("FAIL fast_hdr_en: got %b, required 0", hdr_en); end
    if (ea !== 1'b0)     begin n_err++; $display("FAIL fast_dummy_en: got %b, required 0", ea); end
    spi_byte(8'h00, rx, ea, el);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    exp_b = exp_q.pop_front();
    n_vec += 2;
    if (rx !== exp_b) begin n_err++; $display("FAIL fast_data: got %h, required %h", rx, exp_b); end
    if (el !== 1'b1)  begin n_err++; $display("FAIL fast_data_en: got %b, required 1", el); end
`else
    exp_b = 8'h00;
    n_vec++;
    if (ea !== 1'b0) begin n_err++; $display("FAIL fast_ignored_en: got %b, required 0 (exp byte %h unused)", ea, exp_b); end
`endif
    cs_high();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic       ea, el, hdr_en, any_en;
    addr_q.push_back(24'h000040);
    cs_low();
    send_hdr(8'h03, 24'h000040, hdr_en);
    #30 reset_n = 1'b0;
    #30;
    n_vec += 4;
    if (flash_io1_en !== 1'b0)  begin n_err++; $display("FAIL midrst_io1_en: got %b, required 0", flash_io1_en); end
    if (flash_io1_out !== 1'b0) begin n_err++; $display("FAIL midrst_io1_out: got %b, required 0", flash_io1_out); end
    if (mem_rd !== 1'b0)        begin n_err++; $display("FAIL midrst_mem_rd: got %b, required 0", mem_rd); end
    if (mem_addr !== 24'h0)     begin n_err++; $display("FAIL midrst_mem_addr: got %h, required 000000", mem_addr); end
    reset_n = 1'b1;
    #40;
    send_hdr(8'h03, 24'h000050, any_en);
    spi_byte(8'h00, rx, ea, el);
    any_en = any_en | ea;
    n_vec++;
    if (any_en !== 1'b0) begin n_err++; $display("FAIL midrst_no_response: io1_en seen %b, required 0", any_en); end
    cs_high();
    cs_low();
    read_bytes(24'h000040, 1);
    cs_high();
  endtask

  task automatic test_idle_sclk();
    logic [7:0] rx;
    logic       ea, el;
    spi_byte(8'h03, rx, ea, el);
    spi_byte(8'h9F, rx, ea, el);
    n_vec++;
    if (ea !== 1'b0) begin n_err++; $display("FAIL idle_sclk_en: got %b, required 0", ea); end
    #80;
  endtask

  initial begin
    test_reset();
    test_read();
    test_jedec_id();
    test_wrap();
    test_csn_abort();
    test_ignore_fast();
    test_reset_mid();
    test_idle_sclk();
    #200;
    n_vec++;
    if (addr_q.size() != 0) begin
      n_err++;
      $display("FAIL reads_outstanding: %0d expected mem_rd never seen, required 0", addr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter JEDEC_ID, default 24'hEF4016, the 3 ID bytes returned MSB-first for command 0x9F.
REQ-002 SHALL have parameter MIN_OVERSAMPLE, default 8, the documented minimum clk/flash_clk ratio; it is not used in logic.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port flash_clk, input, 1, the initiator serial clock, asynchronous to clk, SPI mode 0.
REQ-006 SHALL have port flash_csn, input, 1, the active-low chip select, asynchronous.
REQ-007 SHALL have port flash_io0_in, input, 1, the initiator-to-responder data line (MOSI).
REQ-008 SHALL have port flash_io1_out, output, 1, the responder-to-initiator data line (MISO).
REQ-009 SHALL have port flash_io1_en, output, 1, the output enable for flash_io1_out.
REQ-010 SHALL have port mem_rd, output, 1, a one-cycle read strobe to the backing store.
REQ-011 SHALL have port mem_addr, output, 24, the byte address qualified by mem_rd.
REQ-012 SHALL have port mem_rdata, input, 8, the read data, valid exactly 1 clk after mem_rd.

Function
REQ-013 SHALL pass flash_clk, flash_csn and flash_io0_in through 2-flop synchronizers and detect sclk rise and fall from the synchronized value; operation is guaranteed for clk >= 8x flash_clk.
REQ-014 SHALL sample io0 on each detected sclk rise, MSB first, and SHALL update io1_out on each detected sclk fall.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, ID and IGNORE.
REQ-016 SHALL leave IDLE for CMD, with the bit counter cleared, when synchronized csn falls.
REQ-017 SHALL branch after the 8th command bit: 0x03 -> ADDR; 0x9F -> ID; any other opcode (0xAB, 0xFF, ...) -> IGNORE, with io1_en held 0.
REQ-018 SHALL, in ADDR, shift in 24 address bits; on the 24th rise it SHALL pulse mem_rd with mem_addr equal to that address, then enter DATA (or DUMMY per REQ-029).
REQ-019 SHALL, in DATA/ID, assert io1_en and present the byte MSB on the first sclk fall after entry, then 1 bit per fall.
REQ-020 SHALL, when a byte's bit 0 is presented, load the next byte and issue the next mem_rd with address+1, so that data streams without limit.
REQ-021 SHALL wrap the address from 24'hFFFFFF to 24'h000000.
REQ-022 SHALL, in ID, send JEDEC_ID bytes [23:16], [15:8], [7:0], then repeat 8'hFF.
REQ-023 SHALL, on synchronized csn high in any state, return to IDLE in the same cycle, drop io1_en to 0 and abort the partial byte; mem_rd SHALL NOT be issued after csn rises.
REQ-024 SHALL give csn rise priority over a simultaneously detected sclk edge.
REQ-025 SHALL ignore sclk edges while in IDLE.

Reset
REQ-026 SHALL, when reset_n=0 at a clk edge, put the FSM in IDLE, clear the counters and address, drive io1_en=0, io1_out=0 and mem_rd=0, set mem_addr=0, and preset the synchronizers to csn=1, sclk=0.
REQ-027 SHALL, on reset asserted mid-transfer, abort the transfer; after release it SHALL require a fresh csn fall before responding, even if csn is still low.

Configuration
REQ-028 SHALL gate fast-read support with the macro SPI_FLASH_RESPONDER_FAST_READ_EN.
REQ-029 SHALL, with the macro defined, accept opcode 0x0B: ADDR, then DUMMY for 8 sclk rises (io1_en=0, io0 ignored), then DATA as for 0x03, with the mem_rd pulse at the end of ADDR.
REQ-030 SHALL, without the macro, treat 0x0B as IGNORE and omit the DUMMY state logic.

Verification
REQ-031 SHALL pass this test: clk 8x sclk, memory[i]=i[7:0]; send 0x03 000010 and clock 4 bytes -> MISO 0x10,0x11,0x12,0x13; io1_en=1 only during data.
REQ-032 SHALL pass this test: send 0x9F and clock 4 bytes -> 0xEF,0x40,0x16,0xFF.
REQ-033 SHALL pass this test: send 0x03 FFFFFE and clock 3 bytes -> mem_addr FFFFFE, FFFFFF, 000000; data 0xFE,0xFF,0x00.
REQ-034 SHALL pass this test: raise csn after 3 data bits -> io1_en=0 within 3 clk, no further mem_rd; the next 0x03 000020 returns 0x20.
REQ-035 SHALL pass this test: send 0xAB, then 0x0B 000005 + 8 dummy clocks -> no output for 0xAB; 0x05 with the macro, io1_en=0 (IGNORE) without it.
REQ-036 SHALL pass this test: pulse reset_n low mid-READ with csn held low -> outputs at reset values, no response until csn cycles high then low.
